// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM and MEM/WB registers, a req/ack data port
// with ack timeout, and byte-lane steering with load extension. Optional build macro: MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] aluOutE,
    input  logic [31:0] writeDataE,
    input  logic [4:0]  writeRegE,
    input  logic        validE,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic        memReadE,
    input  logic        memWriteE,
    input  logic [1:0]  sizeE,
    input  logic        loadUnsE,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic        dmemAck,
    input  logic [31:0] dmemRdata,
    output logic        stallM,
    output logic [31:0] aluOutM,
    output logic [4:0]  writeRegM,
    output logic        regWriteM,
    output logic [31:0] resultW,
    output logic [4:0]  writeRegW,
    output logic        regWriteW,
    output logic        busErrM
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalignM
`endif
);

    localparam int CW = $clog2(ACK_TIMEOUT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic        validM, regWrM, memToRegM, memReadM, memWriteM, loadUnsM;
    logic [1:0]  sizeM;
    logic [31:0] writeDataM;

    logic        memOpM, trapM, timeoutHit;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata, loadData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            validM     <= 1'b0;
            regWrM     <= 1'b0;
            memToRegM  <= 1'b0;
            memReadM   <= 1'b0;
            memWriteM  <= 1'b0;
            loadUnsM   <= 1'b0;
            sizeM      <= 2'b00;
            aluOutM    <= '0;
            writeDataM <= '0;
            writeRegM  <= '0;
        end else if (!stallM) begin
            validM     <= validE;
            regWrM     <= regWriteE;
            memToRegM  <= memToRegE;
            memReadM   <= memReadE;
            memWriteM  <= memWriteE;
            loadUnsM   <= loadUnsE;
            sizeM      <= sizeE;
            aluOutM    <= aluOutE;
            writeDataM <= writeDataE;
            writeRegM  <= writeRegE;
        end
    end

    assign memOpM    = validM & (memReadM | memWriteM);
    assign regWriteM = validM & regWrM;

`ifdef MISALIGN_TRAP_EN
    // A trapped access never reaches the bus and leaves M in a single cycle.
    assign trapM     = memOpM & (((sizeM == 2'b01) & aluOutM[0]) | (sizeM[1] & (|aluOutM[1:0])));
    assign misalignM = trapM;
`else
    assign trapM     = 1'b0;
`endif

    assign dmemReq    = memOpM & !trapM;
    assign timeoutHit = (state == S_WAIT) & (cnt == CW'(ACK_TIMEOUT - 1)) & !dmemAck;
    assign stallM     = dmemReq & !dmemAck & !timeoutHit;
    assign busErrM    = dmemReq & timeoutHit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // NOTE: every variable written here gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (dmemReq && !dmemAck) begin
                    state_n = S_WAIT;
                    cnt_n   = CW'(1);
                end
            end
            S_WAIT: begin
                if (!dmemReq || dmemAck || timeoutHit) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        laneBe    = 4'b1111;
        laneWdata = writeDataM;
        case (sizeM)
            2'b00: begin
                laneBe    = 4'b0001 << aluOutM[1:0];
                laneWdata = {4{writeDataM[7:0]}};
            end
            2'b01: begin
                laneBe    = 4'b0011 << {aluOutM[1], 1'b0};
                laneWdata = {2{writeDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign dmemAddr  = {aluOutM[31:2], 2'b00};
    assign dmemBe    = dmemReq ? laneBe : 4'b0000;
    assign dmemWe    = dmemReq & memWriteM;
    assign dmemWdata = laneWdata;

    assign byteSel = dmemRdata[{aluOutM[1:0], 3'b000} +: 8];
    assign halfSel = dmemRdata[{aluOutM[1], 4'b0000} +: 16];

    always_comb begin
        loadData = dmemRdata;
        case (sizeM)
            2'b00:   loadData = {{24{byteSel[7] & !loadUnsM}}, byteSel};
            2'b01:   loadData = {{16{halfSel[15] & !loadUnsM}}, halfSel};
            default: ;
        endcase
        // An aborted load still writes back, with zero.
        if (timeoutHit) loadData = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resultW   <= '0;
            writeRegW <= '0;
            regWriteW <= 1'b0;
        end else if (stallM) begin
            regWriteW <= 1'b0;
        end else begin
            resultW   <= memToRegM ? loadData : aluOutM;
            writeRegW <= writeRegM;
            regWriteW <= validM & regWrM & !trapM;
        end
    end

endmodule
